// File: rtl/layernorm_var.sv
// Streaming mean/variance accumulator for layer normalisation over N = 2**LOGN elements.
// Define LNVAR_EPS_EN to add EPS (in LSBs) to the variance before saturation.
module layernorm_var #(
    parameter int IL   = 4,
    parameter int FL   = 16,
    parameter int LOGN = 6,
    parameter int EPS  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IL+FL-1:0]     in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 output_taken,
    output logic [IL+FL-1:0]     mean_out,
    output logic [IL+FL-1:0]     var_out,
    output logic                 out_valid,
    output logic [1:0]           state
);
    localparam int W  = IL + FL;
    localparam int N  = 1 << LOGN;
    localparam int SW = W + LOGN;
    localparam int QW = 2 * W + LOGN;
    localparam int DW = 2 * W + 2;
    localparam int VW = DW - FL + 1;

`ifdef LNVAR_EPS_EN
    localparam logic EPS_ON = 1'b1;
`else
    localparam logic EPS_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        CALC  = 2'b10,
        OUT   = 2'b11
    } state_t;

    state_t                 state_reg, state_next;
    logic signed [SW-1:0]   sum_reg;
    logic [QW-1:0]          sumsq_reg;
    logic [LOGN:0]          count_reg;
    logic                   calc_phase_reg;
    logic signed [W-1:0]    mean_reg;
    logic [2*W-1:0]         msq_reg;

    logic                   accept;
    logic                   last_elem;
    logic signed [W-1:0]    x_s;
    logic signed [2*W-1:0]  sq_s;
    logic signed [2*W-1:0]  mm_s;
    logic signed [DW-1:0]   d;
    logic [DW-1:0]          d_pos;
    logic [VW-1:0]          v_ext;
    logic [VW-1:0]          v_fin;
    logic [W-1:0]           var_sat;
    logic                   unused_bits;

    assign in_ready  = (state_reg == IDLE) || (state_reg == ACCUM);
    assign accept    = in_valid && in_ready;
    assign last_elem = accept && (count_reg == (LOGN+1)'(N - 1));
    assign out_valid = (state_reg == OUT);
    assign state     = state_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (last_elem)
                    state_next = CALC;
                else if (accept)
                    state_next = ACCUM;
            end
            ACCUM: begin
                if (last_elem)
                    state_next = CALC;
            end
            CALC: begin
                if (calc_phase_reg)
                    state_next = OUT;
            end
            OUT: begin
                if (output_taken)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    assign x_s  = $signed(in);
    assign sq_s = x_s * x_s;

    // Second CALC cycle: variance = E[x^2] - mean^2, clamped at zero, then scaled and saturated.
    assign mm_s        = mean_reg * mean_reg;
    assign d           = $signed({2'b00, msq_reg}) - $signed({2'b00, mm_s});
    assign d_pos       = d[DW-1] ? '0 : d;
    assign v_ext       = {1'b0, d_pos[DW-1:FL]};
    assign v_fin       = v_ext + (EPS_ON ? VW'(EPS) : '0);
    assign var_sat     = (|v_fin[VW-1:W]) ? '1 : v_fin[W-1:0];
    assign unused_bits = ^d_pos[FL-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg        <= '0;
            sumsq_reg      <= '0;
            count_reg      <= '0;
            calc_phase_reg <= 1'b0;
            mean_reg       <= '0;
            msq_reg        <= '0;
            mean_out       <= '0;
            var_out        <= '0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        sum_reg   <= sum_reg + {{LOGN{in[W-1]}}, in};
                        sumsq_reg <= sumsq_reg + {{LOGN{1'b0}}, sq_s};
                        count_reg <= count_reg + 1'b1;
                    end
                end
                CALC: begin
                    // First cycle registers the floor-divided sums so the squaring has a full cycle.
                    if (!calc_phase_reg) begin
                        mean_reg       <= sum_reg[SW-1:LOGN];
                        msq_reg        <= sumsq_reg[QW-1:LOGN];
                        calc_phase_reg <= 1'b1;
                    end else begin
                        mean_out       <= mean_reg;
                        var_out        <= var_sat;
                        calc_phase_reg <= 1'b0;
                    end
                end
                OUT: begin
                    if (output_taken) begin
                        sum_reg   <= '0;
                        sumsq_reg <= '0;
                        count_reg <= '0;
                        mean_out  <= '0;
                        var_out   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layernorm_var.sv
// Scoreboard bench for layernorm_var with N=4; expected results are queued at stimulus time.
module tb_layernorm_var;
    localparam int IL   = 4;
    localparam int FL   = 16;
    localparam int LOGN = 2;
    localparam int W    = IL + FL;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  din;
    logic          in_valid;
    logic          in_ready;
    logic          output_taken;
    logic [W-1:0]  mean_out;
    logic [W-1:0]  var_out;
    logic          out_valid;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    layernorm_var #(.IL(IL), .FL(FL), .LOGN(LOGN), .EPS(10)) dut (
        .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .output_taken(output_taken), .mean_out(mean_out), .var_out(var_out),
        .out_valid(out_valid), .state(state)
    );

    function automatic logic [W-1:0] eps_adj(input logic [W-1:0] v);
`ifdef LNVAR_EPS_EN
        int t;
        t = int'(v) + 10;
        return (t > 20'hFFFFF) ? 20'hFFFFF : t[W-1:0];
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else
            $display("ok   %s value=%h", name, act);
    endtask

    // Monitor: each new result presentation is compared with the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h/%h required=none", mean_out, var_out);
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                check("mon_mean", mean_out, e[2*W-1:W]);
                check("mon_var", var_out, e[W-1:0]);
            end
        end
        prev_valid = out_valid;
    end

    task automatic accept_elem(input logic [W-1:0] x);
        int n;
        @(negedge clk);
        din = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
    endtask

    task automatic send_vec(input logic [W-1:0] x0, input logic [W-1:0] x1,
                            input logic [W-1:0] x2, input logic [W-1:0] x3,
                            input int gap, input int hold,
                            input logic [W-1:0] em, input logic [W-1:0] ev);
        logic [W-1:0] xs[4];
        xs = '{x0, x1, x2, x3};
        exp_q.push_back({em, eps_adj(ev)});
        for (int i = 0; i < 4; i++) begin
            accept_elem(xs[i]);
            if (i < 3)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    check("gap_state", W'(state), W'(2'b01));
                end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("calc_state", W'(state), W'(2'b10));
        check("calc1_valid", W'(out_valid), W'(0));
        @(negedge clk);
        check("calc2_valid", W'(out_valid), W'(0));
        @(negedge clk);
        check("latency_valid", W'(out_valid), W'(1));
        for (int h = 0; h < hold; h++) begin
            din = 20'h40000;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold_in_ready", W'(in_ready), W'(0));
            check("hold_mean", mean_out, em);
            check("hold_var", var_out, eps_adj(ev));
        end
        in_valid = 1'b0;
        output_taken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_taken = 1'b0;
        check("taken_state", W'(state), W'(2'b00));
        check("taken_mean_clr", mean_out, W'(0));
        check("taken_var_clr", var_out, W'(0));
    endtask

    initial begin
        reset = 1'b1;
        din = '0;
        in_valid = 1'b0;
        output_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_state", W'(state), W'(2'b00));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_mean", mean_out, W'(0));
        check("rst_var", var_out, W'(0));

        output_taken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        output_taken = 1'b0;
        check("idle_taken_ignored", W'(state), W'(2'b00));

        send_vec(20'h10000, 20'h10000, 20'h10000, 20'h10000, 0, 0, 20'h10000, 20'h00000);
        send_vec(20'h10000, 20'hF0000, 20'h10000, 20'hF0000, 0, 0, 20'h00000, 20'h10000);
        send_vec(20'h00000, 20'h00000, 20'h00000, 20'h40000, 2, 0, 20'h10000, 20'h30000);
        send_vec(20'h7FFFF, 20'h80001, 20'h7FFFF, 20'h80001, 0, 0, 20'h00000, 20'hFFFFF);
        send_vec(20'h10000, 20'h10000, 20'h10000, 20'h10000, 0, 5, 20'h10000, 20'h00000);
        send_vec(20'h10000, 20'hF0000, 20'h10000, 20'hF0000, 0, 0, 20'h00000, 20'h10000);

        accept_elem(20'h40000);
        accept_elem(20'h40000);
        @(negedge clk);
        din = 20'h40000;
        in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        check("midvec_rst_state", W'(state), W'(2'b00));
        check("midvec_rst_valid", W'(out_valid), W'(0));
        check("midvec_rst_ready", W'(in_ready), W'(1));
        send_vec(20'h10000, 20'h10000, 20'h10000, 20'h10000, 0, 0, 20'h10000, 20'h00000);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/layernorm_var.md
LAYERNORM_VAR -- requirements
Module: layernorm_var

Interface
REQ-001 SHALL have parameter IL, default 4, integer bits of the fixed-point word (sign included).
REQ-002 SHALL have parameter FL, default 16, fraction bits of the fixed-point word.
REQ-003 SHALL have parameter LOGN, default 6, log2 of vector length N (LOGN>=1).
REQ-004 SHALL have parameter EPS, default 10, epsilon in LSBs (used only under REQ-027).
REQ-005 SHALL have port clk  input  1  clock; one clock domain.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in  input  IL+FL  element x, signed two's complement Q(IL,FL).
REQ-008 SHALL have port in_valid  input  1  in carries a valid element.
REQ-009 SHALL have port in_ready  output  1  block accepts in this cycle.
REQ-010 SHALL have port output_taken  input  1  downstream consumed mean_out/var_out.
REQ-011 SHALL have port mean_out  output  IL+FL  signed mean, Q(IL,FL).
REQ-012 SHALL have port var_out  output  IL+FL  unsigned variance, Q(IL,FL) bit-weights; feeds the sqrt stage's in.
REQ-013 SHALL have port out_valid  output  1  mean_out/var_out valid.
REQ-014 SHALL have port state  output  2  current FSM state.

Function
REQ-015 SHALL implement states IDLE=2'b00, ACCUM=2'b01, CALC=2'b10, OUT=2'b11.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in CALC and OUT; element accepted on in_valid&&in_ready at posedge.
REQ-017 SHALL, on acceptance: sum += x (signed, IL+FL+LOGN bits); sumsq += x*x (unsigned, 2(IL+FL)+LOGN bits, 2FL frac); count += 1; no overflow possible at these widths.
REQ-018 SHALL transition IDLE->ACCUM on first acceptance, and IDLE/ACCUM->CALC on the acceptance that makes count==N; stalls (in_valid=0) hold state and accumulators.
REQ-019 SHALL in CALC compute: mean = sum>>>LOGN (arithmetic, floor); msq = sumsq>>LOGN; d = msq - mean*mean (2FL frac); d<0 clamps to 0; v = d>>FL; v > 2^(IL+FL)-1 saturates to 2^(IL+FL)-1; register mean_out, var_out; go to OUT next cycle.
REQ-020 SHALL assert out_valid only in OUT; latency: Nth element accepted at edge t -> out_valid=1 after edge t+2.
REQ-021 SHALL hold mean_out, var_out, out_valid stable in OUT until output_taken=1; then at that edge go IDLE, clear sum, sumsq, count, mean_out, var_out.
REQ-022 SHALL ignore output_taken outside OUT and in_valid while in_ready=0 (element dropped, no state change).
REQ-023 SHALL permit a new vector's first element in the cycle after the OUT->IDLE transition (no same-cycle overlap).

Reset
REQ-024 SHALL on reset: state=IDLE, sum=0, sumsq=0, count=0, mean_out=0, var_out=0, out_valid=0, in_ready=1 after the edge.
REQ-025 SHALL let reset win over any simultaneous in_valid or output_taken and discard partial vectors from any state.

Configuration
REQ-026 SHALL use macro LNVAR_EPS_EN to compile epsilon addition in or out.
REQ-027 SHALL, with LNVAR_EPS_EN defined, compute var_out = sat(v + EPS) so var_out>=EPS; without it, var_out = v, EPS unused.

Verification (IL=4, FL=16, LOGN=2, N=4, LNVAR_EPS_EN undefined unless noted)
REQ-028 SHALL cover: 4x in=0x10000 (1.0), output_taken=1 -> out_valid 2 cycles after last accept, mean_out=0x10000, var_out=0x00000, state back to 00.
REQ-029 SHALL cover: in = 1.0,-1.0,1.0,-1.0 (0x10000,0xF0000,0x10000,0xF0000) -> mean_out=0x00000, var_out=0x10000.
REQ-030 SHALL cover: in = 0,0,0,4.0 (0x40000) with 2-cycle in_valid gaps -> mean_out=0x10000, var_out=0x30000; state stays 01 through gaps.
REQ-031 SHALL cover: in alternating 0x7FFFF/0x80001 (~±8) -> var ~64 saturates: var_out=0xFFFFF; with LNVAR_EPS_EN, vector 4x0x10000 -> var_out=0x0000A.
REQ-032 SHALL cover: in OUT hold output_taken=0 five cycles with in_valid=1 -> in_ready=0, outputs unchanged, extra elements dropped; next vector result unaffected.
REQ-033 SHALL cover: reset asserted after 2 accepted elements -> state=00, out_valid=0; following 4x0x10000 vector gives var_out=0, mean_out=0x10000.
